// File: rtl/ibindct_8pt_if.sv
// ============================================================================
// Module   : ibindct_8pt_if
// Purpose  : Coefficient-in / sample-out bundle for the 8-point inverse binDCT.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ibindct_8pt_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic signed [IN_WIDTH-1:0]  y_in  [0:7];
    logic                        valid_in;
    logic                        ready_out;
    logic signed [OUT_WIDTH-1:0] x_out [0:7];
    logic                        valid_out;
    logic                        sat_out;

    modport master (
        output y_in,
        output valid_in,
        input  ready_out,
        input  x_out,
        input  valid_out,
        input  sat_out
    );

    modport slave (
        input  y_in,
        input  valid_in,
        output ready_out,
        output x_out,
        output valid_out,
        output sat_out
    );
endinterface

`default_nettype wire

// File: rtl/ibindct_8pt.sv
// ============================================================================
// Module   : ibindct_8pt
// Purpose  : 8-point inverse binDCT; one vector per 5 cycles, rounded and
//            saturated integer samples out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibindct_8pt #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int FRAC_BITS = 12
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ibindct_8pt_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } state_t;

    localparam logic signed [IN_WIDTH:0] c_rnd_half =
        {{(IN_WIDTH-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] c_sat_max =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] c_sat_min = ~c_sat_max;

    // Butterfly at IN_WIDTH+1 bits; dropping the LSB is the floor >>>1.
    function automatic logic signed [IN_WIDTH-1:0] half_bfly(
        input logic signed [IN_WIDTH-1:0] p,
        input logic signed [IN_WIDTH-1:0] q,
        input logic                       sub
    );
        logic signed [IN_WIDTH:0] s;
        s = sub ? ({p[IN_WIDTH-1], p} - {q[IN_WIDTH-1], q})
                : ({p[IN_WIDTH-1], p} + {q[IN_WIDTH-1], q});
        return s[IN_WIDTH:1];
    endfunction

    state_t                      state_q, state_d;
    logic signed [IN_WIDTH-1:0]  pipe_q [0:7];
    logic signed [IN_WIDTH-1:0]  pipe_d [0:7];
    logic signed [OUT_WIDTH-1:0] x_q    [0:7];
    logic signed [OUT_WIDTH-1:0] x_d    [0:7];
    logic                        valid_q, valid_d;
    logic                        sat_q, sat_d;

    logic signed [IN_WIDTH-1:0]  w_c0, w_c1, w_c2, w_c3, w_c4, w_c5, w_c6;
    logic signed [IN_WIDTH-1:0]  w_s2 [0:7];
    logic signed [IN_WIDTH-1:0]  w_a5, w_a6;
    logic signed [IN_WIDTH-1:0]  w_xf [0:7];
    logic signed [OUT_WIDTH-1:0] w_xr [0:7];
    logic [7:0]                  w_lane_sat;

    // Working bank slots after capture: d0 d1 d2 d3 d4 d5 d6 c7.
    assign w_c1 = (pipe_q[0] >>> 1) - pipe_q[1];
    assign w_c0 = pipe_q[0] - w_c1;
    assign w_c3 = pipe_q[3] - ((pipe_q[2] >>> 2) + (pipe_q[2] >>> 3));
    assign w_c2 = pipe_q[2] + ((w_c3 >>> 2) + (w_c3 >>> 3));
    assign w_c6 = pipe_q[6] + (pipe_q[5] >>> 1);
    assign w_c5 = pipe_q[5] - ((w_c6 >>> 1) + (w_c6 >>> 2) + (w_c6 >>> 3));
    assign w_c4 = pipe_q[4] + (pipe_q[7] >>> 3);

    // Slots after S2: a0 a1 a2 a3 a4 b1 b0 a7.
    assign w_s2[0] = half_bfly(pipe_q[0], pipe_q[3], 1'b0);
    assign w_s2[3] = half_bfly(pipe_q[0], pipe_q[3], 1'b1);
    assign w_s2[1] = half_bfly(pipe_q[1], pipe_q[2], 1'b0);
    assign w_s2[2] = half_bfly(pipe_q[1], pipe_q[2], 1'b1);
    assign w_s2[4] = half_bfly(pipe_q[4], pipe_q[5], 1'b0);
    assign w_s2[5] = half_bfly(pipe_q[4], pipe_q[5], 1'b1);
    assign w_s2[7] = half_bfly(pipe_q[7], pipe_q[6], 1'b0);
    assign w_s2[6] = half_bfly(pipe_q[7], pipe_q[6], 1'b1);

    // S3 replaces b1/b0 in place with a5/a6.
    assign w_a5 = ((pipe_q[6] >>> 1) + (pipe_q[6] >>> 3)) - pipe_q[5];
    assign w_a6 = pipe_q[6] - ((w_a5 >>> 2) + (w_a5 >>> 3));

    assign w_xf[0] = half_bfly(pipe_q[0], pipe_q[7], 1'b0);
    assign w_xf[7] = half_bfly(pipe_q[0], pipe_q[7], 1'b1);
    assign w_xf[1] = half_bfly(pipe_q[1], pipe_q[6], 1'b0);
    assign w_xf[6] = half_bfly(pipe_q[1], pipe_q[6], 1'b1);
    assign w_xf[2] = half_bfly(pipe_q[2], pipe_q[5], 1'b0);
    assign w_xf[5] = half_bfly(pipe_q[2], pipe_q[5], 1'b1);
    assign w_xf[3] = half_bfly(pipe_q[3], pipe_q[4], 1'b0);
    assign w_xf[4] = half_bfly(pipe_q[3], pipe_q[4], 1'b1);

    // Rounding is done one bit wider so the half-LSB add cannot wrap.
    always_comb begin
        logic signed [IN_WIDTH:0] r;
        r          = '0;
        w_lane_sat = '0;
        for (int k = 0; k < 8; k++) begin
            r = {w_xf[k][IN_WIDTH-1], w_xf[k]} + c_rnd_half;
            r = r >>> FRAC_BITS;
            if (r > c_sat_max) begin
                w_xr[k]       = c_sat_max[OUT_WIDTH-1:0];
                w_lane_sat[k] = 1'b1;
            end else if (r < c_sat_min) begin
                w_xr[k]       = c_sat_min[OUT_WIDTH-1:0];
                w_lane_sat[k] = 1'b1;
            end else begin
                w_xr[k]       = r[OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.valid_in) state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pipe_d[i] = pipe_q[i];
            x_d[i]    = x_q[i];
        end
        sat_d   = sat_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    pipe_d[0] = bus.y_in[0];
                    pipe_d[1] = bus.y_in[4];
                    pipe_d[2] = bus.y_in[6];
                    pipe_d[3] = bus.y_in[2];
                    pipe_d[4] = bus.y_in[7];
                    pipe_d[5] = bus.y_in[5];
                    pipe_d[6] = bus.y_in[3];
                    pipe_d[7] = bus.y_in[1];
                end
            end
            ST_S1: begin
                pipe_d[0] = w_c0;
                pipe_d[1] = w_c1;
                pipe_d[2] = w_c2;
                pipe_d[3] = w_c3;
                pipe_d[4] = w_c4;
                pipe_d[5] = w_c5;
                pipe_d[6] = w_c6;
            end
            ST_S2: begin
                for (int i = 0; i < 8; i++) pipe_d[i] = w_s2[i];
            end
            ST_S3: begin
                pipe_d[5] = w_a5;
                pipe_d[6] = w_a6;
            end
            ST_S4: begin
                for (int i = 0; i < 8; i++) x_d[i] = w_xr[i];
                sat_d   = |w_lane_sat;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                pipe_q[i] <= '0;
                x_q[i]    <= '0;
            end
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 8; i++) begin
                pipe_q[i] <= pipe_d[i];
                x_q[i]    <= x_d[i];
            end
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.ready_out = (state_q == ST_IDLE);
    assign bus.valid_out = valid_q;
    assign bus.sat_out   = sat_q;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_lane
            assign bus.x_out[k] = x_q[k];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ibindct_8pt.sv
// ============================================================================
// Module   : tb_ibindct_8pt
// Purpose  : Self-checking bench for ibindct_8pt against a forward binDCT model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibindct_8pt;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int FRAC  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibindct_8pt_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut_if ();

    ibindct_8pt #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FRAC_BITS(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    int                      xs [8];
    int                      ex [8];
    logic signed [IN_W-1:0]  ys [8];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s x[%0d]", tag, i), dut_if.x_out[i], ex[i]);
    endtask

    // Forward binDCT: samples scaled to Q.FRAC, then butterflies and lifting.
    task automatic fwd_model();
        longint X [8];
        longint a0, a1, a2, a3, a4, a5, a6, a7, b0, b1;
        longint c0, c1, c2, c3, c4, c5, c6, c7, d0, d1, d2, d3, d4, d5, d6;
        for (int i = 0; i < 8; i++) X[i] = longint'(xs[i]) * 4096;
        a0 = X[0] + X[7];  a7 = X[0] - X[7];
        a1 = X[1] + X[6];  a6 = X[1] - X[6];
        a2 = X[2] + X[5];  a5 = X[2] - X[5];
        a3 = X[3] + X[4];  a4 = X[3] - X[4];
        b0 = a6 + ((a5 >>> 2) + (a5 >>> 3));
        b1 = ((b0 >>> 1) + (b0 >>> 3)) - a5;
        c0 = a0 + a3;  c3 = a0 - a3;
        c1 = a1 + a2;  c2 = a1 - a2;
        c4 = a4 + b1;  c5 = a4 - b1;
        c7 = a7 + b0;  c6 = a7 - b0;
        d0 = c0 + c1;
        d1 = (d0 >>> 1) - c1;
        d2 = c2 - ((c3 >>> 2) + (c3 >>> 3));
        d3 = c3 + ((d2 >>> 2) + (d2 >>> 3));
        d5 = c5 + ((c6 >>> 1) + (c6 >>> 2) + (c6 >>> 3));
        d6 = c6 - (d5 >>> 1);
        d4 = c4 - (c7 >>> 3);
        ys[0] = IN_W'(d0);  ys[1] = IN_W'(c7);  ys[2] = IN_W'(d3);  ys[3] = IN_W'(d6);
        ys[4] = IN_W'(d1);  ys[5] = IN_W'(d5);  ys[6] = IN_W'(d2);  ys[7] = IN_W'(d4);
    endtask

    task automatic drive(input logic v);
        for (int i = 0; i < 8; i++) dut_if.y_in[i] = ys[i];
        dut_if.valid_in = v;
    endtask

    task automatic set_dc(input logic signed [IN_W-1:0] y0, input int e);
        for (int i = 0; i < 8; i++) begin
            ys[i] = '0;
            ex[i] = e;
        end
        ys[0] = y0;
    endtask

    // One transaction: ys in, ex/esat expected, latency of 4 edges after accept.
    task automatic run_vec(input string tag, input logic esat);
        int lat;
        @(negedge clk);
        drive(1'b1);
        @(posedge clk); #1;
        dut_if.valid_in = 1'b0;
        chk($sformatf("%s ready_after_accept", tag), dut_if.ready_out, 0);
        lat = 0;
        while (dut_if.valid_out !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, 4);
        chk_lanes(tag);
        chk($sformatf("%s sat", tag), dut_if.sat_out, esat);
        chk($sformatf("%s ready_at_valid", tag), dut_if.ready_out, 1);
        @(posedge clk); #1;
        chk($sformatf("%s valid_width", tag), dut_if.valid_out, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [IN_W-1:0] bb  [4][8];
        int                     bbx [4][8];
        int                     pulses;
        int                     e;
        logic                   exp_v;

        dut_if.valid_in = 1'b0;
        for (int i = 0; i < 8; i++) dut_if.y_in[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) ex[i] = 0;
        chk("reset ready", dut_if.ready_out, 1);
        chk("reset valid", dut_if.valid_out, 0);
        chk("reset sat", dut_if.sat_out, 0);
        chk_lanes("reset");
        @(negedge clk);
        rst = 1'b0;

        // DC, rounding and saturation corners
        set_dc(327680, 10);     run_vec("dc10", 1'b0);
        set_dc(8388608, 127);   run_vec("sat_pos", 1'b1);
        set_dc(-8388608, -128); run_vec("sat_neg", 1'b1);
        set_dc(16384, 1);       run_vec("half_up", 1'b0);

        // Extreme 8-bit patterns through the forward model
        for (int i = 0; i < 8; i++) xs[i] = -128;
        ex = xs; fwd_model(); run_vec("all_min", 1'b0);
        for (int i = 0; i < 8; i++) xs[i] = (i % 2 == 0) ? 127 : -128;
        ex = xs; fwd_model(); run_vec("alternate", 1'b0);

        // Random loopback
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(255)) - 128;
            ex = xs;
            fwd_model();
            run_vec($sformatf("loop%0d", n), 1'b0);
        end

        // Busy ignore: vector B offered during S1..S3 must vanish
        set_dc(327680, 10);
        @(negedge clk);
        drive(1'b1);
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            chk($sformatf("busy ready_low%0d", s), dut_if.ready_out, 0);
            @(negedge clk);
            if (s < 3) begin
                for (int i = 0; i < 8; i++) dut_if.y_in[i] = (i == 0) ? -327680 : 1000 * i;
                dut_if.valid_in = 1'b1;
            end else begin
                dut_if.valid_in = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("busy valid", dut_if.valid_out, 1);
        chk_lanes("busy A");
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (dut_if.valid_out === 1'b1) pulses++;
        end
        chk("busy extra_pulses", pulses, 0);

        // Back-to-back with valid_in held high and garbage between accepts
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(255)) - 128;
            fwd_model();
            for (int i = 0; i < 8; i++) begin
                bb[v][i]  = ys[i];
                bbx[v][i] = xs[i];
            end
        end
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k < 20) begin
                for (int i = 0; i < 8; i++)
                    ys[i] = (k % 5 == 0) ? bb[k / 5][i] : IN_W'($urandom());
                drive(1'b1);
            end else begin
                dut_if.valid_in = 1'b0;
            end
            @(posedge clk); #1;
            e     = k + 1;
            exp_v = (e % 5 == 0) && (e <= 20);
            chk($sformatf("b2b valid e%0d", e), dut_if.valid_out, exp_v);
            chk($sformatf("b2b ready e%0d", e), dut_if.ready_out, (e % 5 == 0) || (e > 20));
            if (exp_v) begin
                for (int i = 0; i < 8; i++) ex[i] = bbx[e / 5 - 1][i];
                chk_lanes($sformatf("b2b v%0d", e / 5 - 1));
            end
        end

        // Asynchronous reset during S2
        set_dc(327680, 10);
        @(negedge clk);
        drive(1'b1);
        @(posedge clk); #1;
        dut_if.valid_in = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) ex[i] = 0;
        chk("arst ready", dut_if.ready_out, 1);
        chk("arst valid", dut_if.valid_out, 0);
        chk("arst sat", dut_if.sat_out, 0);
        chk_lanes("arst");
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (dut_if.valid_out === 1'b1) pulses++;
        end
        chk("arst stale_valid", pulses, 0);
        set_dc(-327680, -10);
        run_vec("after_rst", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

`default_nettype wire
